block_mem_ctrl: RTL and testbench

- Main-memory stage directly downstream of the 2-way write-back cache.
- Serves whole 16-byte block reads (refills) and block writes (dirty write-backs) over a clocked valid/ready request and response interface, with a fixed, programmable access latency.
- 1 KB byte-addressed space: 64 blocks of 128 bits, indexed by addr[9:4].
- Provides per-type access counters for miss/write-back statistics.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/sat_counter.sv | 20 ++
 rtl/block_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_block_mem_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and reset-image helper for the block memory stage.
// The reset image gives every byte the low eight bits of its own byte address.
package mem_pkg;

    localparam int BLK_W  = 128;
    localparam int ADDR_W = 10;
    localparam int OFFS_W = 4;
    localparam int NBLK   = 64;
    localparam int IDX_W  = ADDR_W - OFFS_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte j of block i sits at [127-8j -: 8] and holds {i, j}.
    function automatic logic [BLK_W-1:0] init_block(input logic [IDX_W-1:0] idx);
        logic [BLK_W-1:0] blk;
        blk = '0;
        for (int j = 0; j < BLK_W / 8; j++) begin
            blk[BLK_W-1-8*j -: 8] = {idx[3:0], 4'(j)};
        end
        return blk;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
// Cleared asynchronously together with the rest of the memory stage.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/block_mem_ctrl.sv
// Main-memory stage behind the write-back cache: whole-block reads and writes
// with a fixed access latency, one request in flight, and saturating statistics.
module block_mem_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BLK_W-1:0]  req_wdata,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [BLK_W-1:0]  resp_rdata,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    state_t             state_reg;
    state_t             state_next;
    logic [3:0]         lat_reg;
    logic               write_reg;
    logic [IDX_W-1:0]   blk_reg;
    logic [BLK_W-1:0]   wdata_reg;
    logic [BLK_W-1:0]   mem [NBLK];

    logic               accept;
    logic               commit;
    logic               unused_offs;

    assign accept      = req_valid && req_ready;
    assign commit      = (state_reg == BUSY) && (lat_reg == 4'd0);
    assign unused_offs = ^req_addr[OFFS_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (lat_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_reg == IDLE);
        resp_valid = (state_reg == RESP);
    end

    // Request is captured once; the requester may change its inputs afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_reg   <= '0;
            write_reg <= 1'b0;
            blk_reg   <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            lat_reg   <= 4'(LATENCY - 1);
            write_reg <= req_write;
            blk_reg   <= req_addr[ADDR_W-1:OFFS_W];
            wdata_reg <= req_wdata;
        end else if ((state_reg == BUSY) && (lat_reg != 4'd0)) begin
            lat_reg <= lat_reg - 4'd1;
        end
    end

    // Reset restores the address-pattern image, so an aborted write never lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBLK; i++) begin
                mem[i] <= init_block(IDX_W'(i));
            end
        end else if (commit && write_reg) begin
            mem[blk_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else if (commit) begin
            resp_write <= write_reg;
            if (!write_reg) begin
                resp_rdata <= mem[blk_reg];
            end
        end
    end

    logic inc_rd;
    logic inc_wr;

    assign inc_rd = resp_valid && !resp_write;
    assign inc_wr = resp_valid && resp_write;

    sat_counter #(.W(CNT_W)) u_rd_count (
        .clk   (clk),
        .clr_n (reset_n),
        .inc   (inc_rd),
        .count (rd_count)
    );

    sat_counter #(.W(CNT_W)) u_wr_count (
        .clk   (clk),
        .clr_n (reset_n),
        .inc   (inc_wr),
        .count (wr_count)
    );

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Randomized self-checking bench: a default build (LATENCY 4) and a LATENCY 1 /
// 2-bit-counter build run against a plain array model of the memory.
module tb_block_mem_ctrl;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;
    localparam int CW_B  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n      [2];
    logic         req_valid  [2];
    logic         req_write  [2];
    logic [9:0]   req_addr   [2];
    logic [127:0] req_wdata  [2];
    logic         req_ready  [2];
    logic         resp_valid [2];
    logic         resp_write [2];
    logic [127:0] resp_rdata [2];
    logic [15:0]  rd_count   [2];
    logic [15:0]  wr_count   [2];
    logic [15:0]  rd_a, wr_a;
    logic [CW_B-1:0] rd_b, wr_b;

    assign rd_count[0] = rd_a;
    assign wr_count[0] = wr_a;
    assign rd_count[1] = {14'd0, rd_b};
    assign wr_count[1] = {14'd0, wr_b};

    block_mem_ctrl #(.LATENCY(LAT_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_write(resp_write[0]), .resp_rdata(resp_rdata[0]),
        .rd_count(rd_a), .wr_count(wr_a)
    );

    block_mem_ctrl #(.LATENCY(LAT_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_write(resp_write[1]), .resp_rdata(resp_rdata[1]),
        .rd_count(rd_b), .wr_count(wr_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: 64 blocks per instance, counters, last data read.
    logic [127:0] model_mem [2][64];
    int           model_rd  [2];
    int           model_wr  [2];
    logic [127:0] model_last[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic logic [127:0] pattern(input int blk);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r = {r[119:0], 8'(blk * 16 + j)};
        return r;
    endfunction

    task automatic model_reset(input int i);
        for (int b = 0; b < 64; b++) model_mem[i][b] = pattern(b);
        model_rd[i]   = 0;
        model_wr[i]   = 0;
        model_last[i] = '0;
    endtask

    task automatic model_apply(input int i, input logic w, input logic [9:0] a,
                               input logic [127:0] d, output logic [127:0] exp);
        if (w) begin
            model_mem[i][a[9:4]] = d;
            if (model_wr[i] < cmax(i)) model_wr[i]++;
        end else begin
            model_last[i] = model_mem[i][a[9:4]];
            if (model_rd[i] < cmax(i)) model_rd[i]++;
        end
        exp = model_last[i];
    endtask

    task automatic do_reset(input int i);
        req_valid[i] = 1'b0;
        rst_n[i]     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n[i] = 1'b1;
        model_reset(i);
    endtask

    // Drives one request and reports what the DUT returned; callers do the checking.
    task automatic xact(input int i, input logic w, input logic [9:0] a, input logic [127:0] d,
                        output logic [127:0] rdata, output logic rwrite, output int lat,
                        output logic after);
        int t;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        lat    = -1;
        rdata  = '0;
        rwrite = 1'b0;
        after  = 1'b1;
        t = 0;
        while (!req_ready[i] && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        req_write[i] = ~w;
        req_addr[i]  = 10'($urandom);
        req_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
        if (t < 20) begin
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (resp_valid[i]) begin
                    lat = n;
                    break;
                end
            end
        end
        if (lat >= 0) begin
            rdata  = resp_rdata[i];
            rwrite = resp_write[i];
            @(negedge clk);
            after = resp_valid[i];
        end
    endtask

    task automatic test_reset(input int i);
        do_reset(i);
        n_chk += 3;
        if ({req_ready[i], resp_valid[i], resp_write[i]} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl[%0d] got ready/valid/write=%b exp 100", i,
                     {req_ready[i], resp_valid[i], resp_write[i]});
        end
        if (resp_rdata[i] !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_rdata[%0d] got %h exp 0", i, resp_rdata[i]);
        end
        if (rd_count[i] !== 16'd0 || wr_count[i] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts[%0d] got rd=%0d wr=%0d exp 0 0", i, rd_count[i], wr_count[i]);
        end
    endtask

    task automatic test_read_first();
        logic [127:0] rdata, exp, ref_c;
        logic rw, after;
        int lat;
        ref_c = 128'h101112131415161718191A1B1C1D1E1F;
        do_reset(0);
        model_apply(0, 1'b0, 10'h014, '0, exp);
        xact(0, 1'b0, 10'h014, '0, rdata, rw, lat, after);
        n_chk += 5;
        if (lat !== LAT_A) begin
            n_fail++;
            $display("FAIL read_first_latency got %0d exp %0d", lat, LAT_A);
        end
        if (rdata !== ref_c || rdata !== exp) begin
            n_fail++;
            $display("FAIL read_first_rdata got %h exp %h", rdata, ref_c);
        end
        if (rw !== 1'b0 || after !== 1'b0) begin
            n_fail++;
            $display("FAIL read_first_pulse got write=%b after=%b exp 0 0", rw, after);
        end
        if (rd_count[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL read_first_rd_count got %0d exp 1", rd_count[0]);
        end
        if (wr_count[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL read_first_wr_count got %0d exp 0", wr_count[0]);
        end
    endtask

    task automatic test_write_read();
        logic [127:0] d, rdata, exp;
        logic rw, after;
        int lat;
        d = 128'hDEADBEEF_00112233_44556677_8899AABB;
        do_reset(0);
        model_apply(0, 1'b1, 10'h2A7, d, exp);
        xact(0, 1'b1, 10'h2A7, d, rdata, rw, lat, after);
        n_chk += 2;
        if (rw !== 1'b1 || lat !== LAT_A) begin
            n_fail++;
            $display("FAIL write_resp got write=%b lat=%0d exp 1 %0d", rw, lat, LAT_A);
        end
        if (rdata !== 128'd0) begin
            n_fail++;
            $display("FAIL write_rdata_hold got %h exp 0", rdata);
        end
        model_apply(0, 1'b0, 10'h2A0, '0, exp);
        xact(0, 1'b0, 10'h2A0, '0, rdata, rw, lat, after);
        n_chk += 2;
        if (rdata !== d || rdata !== exp) begin
            n_fail++;
            $display("FAIL write_read_rdata got %h exp %h", rdata, d);
        end
        if (rd_count[0] !== 16'd1 || wr_count[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL write_read_counts got rd=%0d wr=%0d exp 1 1", rd_count[0], wr_count[0]);
        end
    endtask

    task automatic test_random(input int i, input int n);
        logic [127:0] d, rdata, exp;
        logic [9:0] a;
        logic w, rw, after;
        int lat;
        for (int k = 0; k < n; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 10'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            model_apply(i, w, a, d, exp);
            xact(i, w, a, d, rdata, rw, lat, after);
            n_chk += 4;
            if (lat !== lat_of(i) || after !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d] timing got lat=%0d after=%b exp %0d 0", i, lat, after, lat_of(i));
            end
            if (rw !== w) begin
                n_fail++;
                $display("FAIL random[%0d] resp_write got %b exp %b", i, rw, w);
            end
            if (rdata !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] rdata addr=%h got %h exp %h", i, a, rdata, exp);
            end
            if (rd_count[i] !== 16'(model_rd[i]) || wr_count[i] !== 16'(model_wr[i])) begin
                n_fail++;
                $display("FAIL random[%0d] counts got rd=%0d wr=%0d exp %0d %0d", i,
                         rd_count[i], wr_count[i], model_rd[i], model_wr[i]);
            end
        end
    endtask

    // req_valid held high across a 3-request burst: write X, read X, read random.
    task automatic test_back_to_back();
        logic         w_l [3];
        logic [9:0]   a_l [3];
        logic [127:0] d_l [3];
        logic [127:0] exp_q [$];
        logic         expw_q [$];
        logic [127:0] e;
        logic         ew, acc, exp_rv, exp_rdy;
        int last_acc, nacc, nresp;
        w_l[0] = 1'b1; a_l[0] = 10'($urandom); d_l[0] = {$urandom, $urandom, $urandom, $urandom};
        w_l[1] = 1'b0; a_l[1] = {a_l[0][9:4], 4'($urandom)}; d_l[1] = '0;
        w_l[2] = 1'b0; a_l[2] = 10'($urandom); d_l[2] = '0;
        last_acc = -100;
        nacc = 0;
        nresp = 0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = w_l[0];
        req_addr[0]  = a_l[0];
        req_wdata[0] = d_l[0];
        for (int c = 0; c < 80 && nresp < 3; c++) begin
            if (c > 0) @(negedge clk);
            exp_rv  = (c == last_acc + LAT_A + 1);
            exp_rdy = (c >= last_acc + LAT_A + 2);
            n_chk += 2;
            if (resp_valid[0] !== exp_rv) begin
                n_fail++;
                $display("FAIL b2b_resp_valid cyc=%0d got %b exp %b", c, resp_valid[0], exp_rv);
            end
            if (req_ready[0] !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_req_ready cyc=%0d got %b exp %b", c, req_ready[0], exp_rdy);
            end
            if (resp_valid[0] && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ew = expw_q.pop_front();
                nresp++;
                n_chk++;
                if (resp_rdata[0] !== e || resp_write[0] !== ew) begin
                    n_fail++;
                    $display("FAIL b2b_data resp=%0d got %h/%b exp %h/%b", nresp,
                             resp_rdata[0], resp_write[0], e, ew);
                end
            end
            acc = req_valid[0] && req_ready[0];
            @(posedge clk);
            #1;
            if (acc) begin
                model_apply(0, w_l[nacc], a_l[nacc], d_l[nacc], e);
                exp_q.push_back(e);
                expw_q.push_back(w_l[nacc]);
                last_acc = c;
                nacc++;
                if (nacc == 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_write[0] = w_l[nacc];
                    req_addr[0]  = a_l[nacc];
                    req_wdata[0] = d_l[nacc];
                end
            end
        end
        n_chk++;
        if (nresp !== 3) begin
            n_fail++;
            $display("FAIL b2b_resp_count got %0d exp 3", nresp);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [127:0] rdata;
        logic rw, after;
        int lat, seen;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 10'h3F0;
        req_wdata[0] = '1;
        while (!req_ready[0]) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        #1;
        n_chk += 2;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async got ready=%b valid=%b exp 1 0", req_ready[0], resp_valid[0]);
        end
        if (rd_count[0] !== 16'd0 || wr_count[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_counts got rd=%0d wr=%0d exp 0 0", rd_count[0], wr_count[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        model_reset(0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid[0]) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_pulse got %0d pulses exp 0", seen);
        end
        xact(0, 1'b0, 10'h3F0, '0, rdata, rw, lat, after);
        n_chk++;
        if (rdata !== pattern(63)) begin
            n_fail++;
            $display("FAIL midrst_read got %h exp %h", rdata, pattern(63));
        end
    endtask

    task automatic test_lat1_sat();
        logic [127:0] rdata, exp, ref_c;
        logic rw, after;
        int lat;
        ref_c = 128'h000102030405060708090A0B0C0D0E0F;
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            model_apply(1, 1'b0, 10'h000, '0, exp);
            xact(1, 1'b0, 10'(k), '0, rdata, rw, lat, after);
            n_chk += 3;
            if (lat !== LAT_B || rdata !== ref_c) begin
                n_fail++;
                $display("FAIL lat1_read k=%0d got lat=%0d rdata=%h exp %0d %h", k, lat, rdata, LAT_B, ref_c);
            end
            if (rd_count[1] !== 16'((k < 3) ? k + 1 : 3)) begin
                n_fail++;
                $display("FAIL sat_rd_count k=%0d got %0d exp %0d", k, rd_count[1], (k < 3) ? k + 1 : 3);
            end
            if (wr_count[1] !== 16'd0) begin
                n_fail++;
                $display("FAIL sat_wr_count k=%0d got %0d exp 0", k, wr_count[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            model_reset(i);
        end
        #2;
        test_reset(0);
        test_reset(1);
        test_read_first();
        test_write_read();
        test_random(0, 20);
        test_back_to_back();
        test_reset_mid_write();
        test_lat1_sat();
        test_random(1, 20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
